// File: rtl/cbus_arbiter.sv
// CBus arbiter: grants one upstream master at a time and holds the grant until the downstream reports last.
// Round-robin by default; define CBUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).

package cbus_pkg;

  localparam logic [1:0] CBUS_BURST_FIXED = 2'd0;
  localparam logic [1:0] CBUS_BURST_INCR  = 2'd1;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cbus_req_t  [NUM_MASTERS-1:0] ireqs,
  output cbus_resp_t [NUM_MASTERS-1:0] iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] owner_nxt_s;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] rr_ptr_nxt_s;
  logic [IDX_W-1:0] winner_s;
  logic             any_valid_s;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W:0]   cand_s;
  logic             hit_s;
  logic             done_s;

  // Explicit modulo wrap so non-power-of-2 master counts return to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_MASTERS - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  // Winner search: first valid master scanning upward from rr_ptr (rr_ptr is 0 under fixed priority).
  always_comb begin
    winner_s    = '0;
    any_valid_s = 1'b0;
    sum_s       = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      sum_s       = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
      cand_s      = (sum_s >= (IDX_W+1)'(NUM_MASTERS)) ? (sum_s - (IDX_W+1)'(NUM_MASTERS)) : sum_s;
      hit_s       = !any_valid_s && ireqs[cand_s[IDX_W-1:0]].valid;
      winner_s    = hit_s ? cand_s[IDX_W-1:0] : winner_s;
      any_valid_s = any_valid_s | ireqs[cand_s[IDX_W-1:0]].valid;
    end
  end

  assign done_s = oresp.ready && oresp.last;

  // Next-state logic for the grant FSM and the fairness pointer.
  always_comb begin
    state_nxt_s  = state_r;
    owner_nxt_s  = owner_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (any_valid_s) begin
          state_nxt_s = BUSY;
          owner_nxt_s = winner_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (done_s) begin
          state_nxt_s = IDLE;
`ifdef CBUS_ARB_FIXED_PRIO_EN
          rr_ptr_nxt_s = '0;
`else
          rr_ptr_nxt_s = wrap_inc(owner_r);
`endif
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        owner_nxt_s = '0;
      end
    endcase
  end

  // State registers; async reset clears the grant so outputs drop immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Output steering: owner sees the downstream directly, everyone else sees zero.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    case (state_r)
      BUSY: begin
        oreq            = ireqs[owner_r];
        iresps[owner_r] = oresp;
      end
      IDLE: begin
        oreq   = '0;
        iresps = '0;
      end
      default: begin
        oreq   = '0;
        iresps = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  cbus_req_t  [N-1:0]   ireqs;
  cbus_resp_t [N-1:0]   iresps;
  cbus_req_t            oreq;
  cbus_resp_t           oresp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_MASTERS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ireqs (ireqs),
    .iresps(iresps),
    .oreq  (oreq),
    .oresp (oresp)
  );

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr, input logic [7:0] strobe,
                                       input logic [63:0] data, input logic [7:0] len, input logic [1:0] burst);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'd3;
    r.addr     = addr;
    r.strobe   = strobe;
    r.data     = data;
    r.len      = len;
    r.burst    = burst;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_beats = 0;
  bit m_done [N];
  int c;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
    end else begin
      for (int i = 0; i < N; i++) m_done[i] = 1'b0;
      if (m_busy) begin
        if (oresp.ready && oresp.last) begin
          m_busy = 1'b0;
          m_done[m_owner] = 1'b1;
          m_beats = 0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
          m_ptr = (m_owner + 1) % N;
`endif
        end else if (oresp.ready) begin
          m_beats++;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (ireqs[c].valid) begin
            m_busy = 1'b1;
            m_owner = c;
            break;
          end
        end
      end
    end
  end

  cbus_req_t          e_req;
  cbus_resp_t [N-1:0] e_resp;

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    e_req  = '0;
    e_resp = '0;
    if (m_busy) begin
      e_req          = ireqs[m_owner];
      e_resp[m_owner] = oresp;
    end
    chk("cyc_oreq", 128'(oreq), 128'(e_req));
    for (int i = 0; i < N; i++) chk("cyc_iresp", 128'(iresps[i]), 128'(e_resp[i]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ireqs = '0;
    oresp = '0;
    tick();
    reset = 1'b1;
  endtask

  cbus_req_t pend [N];
  bit        has  [N];
  cbus_req_t r0, r1, r2;
  logic [7:0] blen;
  int exp_own [10];

  initial begin
    ireqs = '0;
    oresp = '0;
    #2;
    // Reset state
    chk("reset_oreq", 128'(oreq), 128'(0));
    chk("reset_iresps", 128'(iresps), 128'(0));
    tick();
    reset = 1'b1;

    // Single master FIXED read
    r0 = mk_req(1'b0, 32'h8000_0000, 8'h00, 64'h0, 8'd0, CBUS_BURST_FIXED);
    ireqs[0] = r0;
    #2 chk("t1_idle_cycleN", 128'(oreq), 128'(0));
    tick();
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'h1122_3344_5566_7788;
    #2;
    chk("t1_oreq_addr", 128'(oreq.addr), 128'(32'h8000_0000));
    chk("t1_oreq_valid", 128'(oreq.valid), 128'(1'b1));
    chk("t1_iresp0_data", 128'(iresps[0].data), 128'(64'h1122_3344_5566_7788));
    chk("t1_iresp0_ready", 128'(iresps[0].ready), 128'(1'b1));
    chk("t1_iresp1_zero", 128'(iresps[1]), 128'(0));
    tick();
    ireqs = '0; oresp = '0;
    #2 chk("t1_idle_after", 128'(oreq), 128'(0));
    tick();

    // Burst hold: master 1 INCR len=7, master 0 requests meanwhile
    r1 = mk_req(1'b0, 32'h8000_0100, 8'h00, 64'h0, 8'd7, CBUS_BURST_INCR);
    r0 = mk_req(1'b0, 32'h8000_0200, 8'h00, 64'h0, 8'd0, CBUS_BURST_FIXED);
    ireqs[1] = r1;
    tick();
    ireqs[0] = r0;
    for (int b = 0; b < 8; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == 7);
      oresp.data  = 64'(b) + 64'h100;
      #2;
      chk("t3_oreq_addr", 128'(oreq.addr), 128'(32'h8000_0100));
      chk("t3_oreq_len", 128'(oreq.len), 128'(8'd7));
      chk("t3_m0_ready", 128'(iresps[0].ready), 128'(1'b0));
      chk("t3_m1_data", 128'(iresps[1].data), 128'(64'(b) + 64'h100));
      tick();
    end
    ireqs[1] = '0; oresp = '0;
    #2 chk("t3_gap_idle", 128'(oreq.valid), 128'(1'b0));
    tick();
    #2 chk("t3_m0_granted", 128'(oreq.addr), 128'(32'h8000_0200));
    oresp.ready = 1'b1; oresp.last = 1'b1;
    tick();
    ireqs = '0; oresp = '0;

    // Arbitration with two masters continuously valid, single-beat transfers
    do_reset();
`ifdef CBUS_ARB_FIXED_PRIO_EN
    exp_own = '{-1, 0, -1, 0, -1, 0, -1, 0, -1, 1};
`else
    exp_own = '{-1, 0, -1, 1, -1, 0, -1, 1, -1, 1};
`endif
    ireqs[0] = mk_req(1'b0, 32'h8000_00A0, 8'h00, 64'h0, 8'd0, CBUS_BURST_FIXED);
    ireqs[1] = mk_req(1'b0, 32'h8000_00B0, 8'h00, 64'h0, 8'd0, CBUS_BURST_FIXED);
    oresp.ready = 1'b1; oresp.last = 1'b1;
    for (int cy = 0; cy < 10; cy++) begin
      if (cy == 8) ireqs[0] = '0;
      #2;
      if (exp_own[cy] < 0) chk("t4_idle", 128'(oreq.valid), 128'(1'b0));
      else chk("t4_grant", 128'(oreq.addr), 128'((exp_own[cy] == 0) ? 32'h8000_00A0 : 32'h8000_00B0));
      tick();
    end
    ireqs = '0; oresp = '0;
    tick();

    // Write pass-through
    r1 = mk_req(1'b1, 32'h8000_1000, 8'h0F, 64'hDEAD_BEEF_CAFE_F00D, 8'd0, CBUS_BURST_FIXED);
    ireqs[1] = r1;
    tick();
    oresp.ready = 1'b1; oresp.last = 1'b1;
    #2;
    chk("t5_strobe", 128'(oreq.strobe), 128'(8'h0F));
    chk("t5_data", 128'(oreq.data), 128'(64'hDEAD_BEEF_CAFE_F00D));
    chk("t5_addr", 128'(oreq.addr), 128'(32'h8000_1000));
    chk("t5_is_write", 128'(oreq.is_write), 128'(1'b1));
    tick();
    ireqs = '0; oresp = '0;
    tick();

    // Async reset mid-burst
    ireqs[0] = mk_req(1'b0, 32'h8000_2000, 8'h00, 64'h0, 8'd7, CBUS_BURST_INCR);
    tick();
    oresp.ready = 1'b1; oresp.last = 1'b0; oresp.data = 64'h55;
    tick();
    tick();
    #2 chk("t6_busy_before", 128'(oreq.valid), 128'(1'b1));
    reset = 1'b0;
    #1;
    chk("t6_oreq_cleared", 128'(oreq), 128'(0));
    chk("t6_iresps_cleared", 128'(iresps), 128'(0));
    tick();
    ireqs = '0; oresp = '0;
    reset = 1'b1;
    ireqs[1] = mk_req(1'b0, 32'h8000_3000, 8'h00, 64'h0, 8'd0, CBUS_BURST_FIXED);
    #2 chk("t6_idle_after_reset", 128'(oreq.valid), 128'(1'b0));
    tick();
    #2 chk("t6_regrant", 128'(oreq.addr), 128'(32'h8000_3000));
    oresp.ready = 1'b1; oresp.last = 1'b1;
    tick();
    ireqs = '0; oresp = '0;
    tick();

    // Randomized traffic; masters hold their request until their last beat
    for (int i = 0; i < N; i++) has[i] = 1'b0;
    for (int cy = 0; cy < 3000; cy++) begin
      for (int i = 0; i < N; i++) begin
        if (m_done[i]) has[i] = 1'b0;
        if (!has[i] && $urandom_range(0, 3) == 0) begin
          r2 = mk_req(1'($urandom), $urandom, 8'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 0) ? CBUS_BURST_FIXED : CBUS_BURST_INCR);
          pend[i] = r2;
          has[i] = 1'b1;
        end
        if (has[i]) begin
          ireqs[i] = pend[i];
        end else begin
          r2 = mk_req(1'($urandom), $urandom, 8'($urandom), {$urandom, $urandom}, 8'($urandom), 2'($urandom));
          r2.valid = 1'b0;
          ireqs[i] = r2;
        end
      end
      oresp.ready = ($urandom_range(0, 2) != 0);
      oresp.data  = {$urandom, $urandom};
      if (m_busy) begin
        blen = (pend[m_owner].burst == CBUS_BURST_INCR) ? pend[m_owner].len : 8'd0;
        oresp.last = oresp.ready && (m_beats == int'(blen));
      end else begin
        oresp.last = 1'($urandom);
      end
      tick();
    end

    ireqs = '0; oresp = '0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Arbitrates several cache-side CBus masters (icache, dcache, uncached path) onto the single CBus that feeds the memory-side CBus-to-SRAM/AXI bridge. Grants exactly one master at a time and holds the grant for the whole transaction, including bursts, until the downstream response reports `last`. Round-robin is the default policy; a macro can select fixed priority instead.

## Interface
- `NUM_MASTERS`, 2, number of upstream CBus masters (2..8); master 0 has the highest priority under fixed priority.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  **asynchronous, active-low** reset.
- `ireqs`  in  `cbus_req_t [NUM_MASTERS-1:0]`  upstream requests (`valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`, `burst`).
- `iresps`  out  `cbus_resp_t [NUM_MASTERS-1:0]`  upstream responses (`ready`, `last`, `data`).
- `oreq`  out  `cbus_req_t`  request to the downstream bridge.
- `oresp`  in  `cbus_resp_t`  response from the downstream bridge.

## Operation
- State machine: `IDLE`, `BUSY`. Registers: `state`, `owner` (clog2(NUM_MASTERS) bits), `rr_ptr` (same width).
- Reset (reset low, asynchronous): `state=IDLE`, `owner=0`, `rr_ptr=0`; `oreq='0`; every `iresps[i]='0`.
- `IDLE`: `oreq='0`; all `iresps='0`. If any `ireqs[i].valid`, the winner is the first valid index scanning `rr_ptr, rr_ptr+1, … mod NUM_MASTERS`; next state `BUSY`, `owner<=winner`. With no valid request, state holds.
- `BUSY`: `oreq=ireqs[owner]` (all fields passed through, unregistered); `iresps[owner]=oresp`; every other `iresps[i]='0`.
- `BUSY` exit: on a cycle with `oresp.ready && oresp.last`, next state `IDLE`, `rr_ptr<=owner+1` (wrap from NUM_MASTERS-1 to 0; for non-power-of-2 counts, wrap explicitly, not by truncation).
- Requests arriving from non-owners while `BUSY` are ignored (they see `ready=0`) and must be held by the master; none are lost or queued.
- Owner dropping `valid` mid-transaction: a protocol violation; the arbiter stays `BUSY` and keeps forwarding until `last` is seen (`oreq.valid=0` is passed through unchanged).
- Write data, strobe, and burst length are never modified; `len` and `burst` belong to the owner for the whole transaction.

## Timing
- Arbitration latency: 1 cycle. A request valid in cycle N (arbiter `IDLE`) is presented on `oreq` in cycle N+1.
- Combinational paths in `BUSY`: `ireqs[owner]`→`oreq` and `oresp`→`iresps[owner]`; no added pipeline delay per beat.
- Beat count follows the downstream side: an INCR burst with `len=L` completes after L+1 ready beats; `last` on the final beat releases the grant.
- Back-to-back transactions: always at least one `IDLE` cycle between consecutive grants, even if requests are pending when `last` arrives.
- Simultaneous `last` and a new request from another master: the completing beat is delivered to the old owner; the new owner is chosen in the following `IDLE` cycle using the updated `rr_ptr`.
- Reset asserted mid-burst: outputs clear immediately (asynchronously); the partially completed transfer is abandoned.

## Configuration
- `CBUS_ARB_FIXED_PRIO_EN`: when defined, the winner is always the lowest-indexed valid master; `rr_ptr` is not updated (it stays at 0). When not defined, round-robin arbitration is used as described above.

## Test plan
- Single master: master 0 issues a FIXED read to addr `0x80000000`, and downstream returns `data=0x1122334455667788` with `ready=1,last=1` → `oreq` equals the master-0 request in cycle N+1, `iresps[0].data=0x1122334455667788`, then `IDLE` for 1 cycle.
- Burst hold: master 1 issues an INCR read with `len=7`, and master 0 requests during the burst → `oreq` stays master 1 for all 8 beats, `iresps[0].ready=0` throughout, and master 0 is granted 1 cycle after master 1's `last`.
- Round-robin fairness: both masters are continuously valid with single-beat transfers → grants alternate 0,1,0,1,… (4 transactions), each separated by one `IDLE` cycle.
- Fixed priority (`CBUS_ARB_FIXED_PRIO_EN` defined): the same stimulus → master 0 wins all 4 grants while it stays valid; master 1 is granted only after master 0 drops `valid`.
- Write pass-through: master 1 writes `strobe=0x0F`, `data=0xDEADBEEFCAFEF00D` to `0x80001000` → `oreq.strobe=0x0F` and `oreq.data` are unchanged.
- Async reset: reset goes low on beat 3 of a `len=7` burst → `oreq` and all `iresps` become 0 before the next clock edge, `state=IDLE`, and after reset is released a new request is granted normally.
